// File: rtl/dec16_rr_arbiter.sv
// Round-robin arbiter sharing one 4-to-16 active-low decoder among 16 active-low requesters.
// Latency: grant registered 1 clk after the request is sampled; 1 dead + 1 idle cycle between grants.
// Backpressure: grant held until done, grantee withdrawal or TIMEOUT expiry; other requesters wait on rq_.
module dec16_rr_arbiter #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk_sys,
    input  logic        clr,
    input  logic [0:15] rq_,
    input  logic        done,
    output logic        en_,
    output logic [3:0]  code,
    output logic [0:15] gnt_,
    output logic        busy,
    output logic        tmo
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam bit         TMO_ON   = (TIMEOUT != 0);
    localparam logic [7:0] TMO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_d;
    logic [3:0]  last;
    logic [3:0]  last_d;
    logic [7:0]  hold_cnt;
    logic [7:0]  hold_cnt_d;
    logic        en_d;
    logic [3:0]  code_d;
    logic [0:15] gnt_d;
    logic        busy_d;
    logic        tmo_d;

    logic        pick_vld;
    logic [3:0]  pick_idx;
    logic [3:0]  cand;
    logic        end_by_owner;
    logic        end_by_tmo;
    logic        grant_end;

    function automatic logic [0:15] dec16(input logic [3:0] sel);
        logic [0:15] v;
        v      = '1;
        v[sel] = 1'b0;
        return v;
    endfunction

    // Search starts just past the last grantee; the 16th candidate wraps back to last itself.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 4'd0;
        cand     = 4'd0;
        for (int i = 1; i <= 16; i++) begin
            cand = last + 4'(i);
            if (!pick_vld && !rq_[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign end_by_owner = done | rq_[code];
    assign end_by_tmo   = TMO_ON && (hold_cnt == TMO_LAST);
    assign grant_end    = end_by_owner | end_by_tmo;

    always_ff @(posedge clk_sys) begin
        if (clr) begin
            state    <= IDLE;
            last     <= 4'd15;
            hold_cnt <= 8'd0;
            en_      <= 1'b1;
            code     <= 4'd0;
            gnt_     <= '1;
            busy     <= 1'b0;
            tmo      <= 1'b0;
        end else begin
            state    <= state_d;
            last     <= last_d;
            hold_cnt <= hold_cnt_d;
            en_      <= en_d;
            code     <= code_d;
            gnt_     <= gnt_d;
            busy     <= busy_d;
            tmo      <= tmo_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (pick_vld)  state_d = GRANT;
            GRANT:   if (grant_end) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d     = last;
        hold_cnt_d = hold_cnt;
        en_d       = en_;
        code_d     = code;
        gnt_d      = gnt_;
        busy_d     = busy;
        tmo_d      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    last_d     = pick_idx;
                    code_d     = pick_idx;
                    hold_cnt_d = 8'd0;
                    en_d       = 1'b0;
                    gnt_d      = dec16(pick_idx);
                    busy_d     = 1'b1;
                end
            end
            GRANT: begin
                hold_cnt_d = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
                if (grant_end) begin
                    en_d   = 1'b1;
                    gnt_d  = '1;
                    busy_d = 1'b1;
                    // An owner-initiated end masks a coincident timeout.
                    tmo_d  = end_by_tmo & ~end_by_owner;
                end
            end
            RELEASE: begin
                en_d   = 1'b1;
                gnt_d  = '1;
                busy_d = 1'b0;
            end
            default: begin
                en_d   = 1'b1;
                gnt_d  = '1;
                busy_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dec16_rr_arbiter.sv
module tb_dec16_rr_arbiter;

    logic        clk_sys = 1'b0;
    logic        clr;
    logic [0:15] rq_;
    logic        done;
    logic        en_;
    logic [3:0]  code;
    logic [0:15] gnt_;
    logic        busy;
    logic        tmo;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        logic [3:0]  code;
        logic [0:15] gnt;
    } exp_t;

    exp_t sb[$];

    dec16_rr_arbiter #(.TIMEOUT(4)) dut (
        .clk_sys (clk_sys),
        .clr     (clr),
        .rq_     (rq_),
        .done    (done),
        .en_     (en_),
        .code    (code),
        .gnt_    (gnt_),
        .busy    (busy),
        .tmo     (tmo)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [0:15] dec16_model(input logic en, input logic [3:0] c);
        logic [0:15] o;
        for (int n = 0; n < 16; n++) o[n] = en | (c != 4'(n));
        return o;
    endfunction

    function automatic logic [0:15] req_low(input int a, input int b);
        logic [0:15] v;
        v = '1;
        if (a >= 0) v[a] = 1'b0;
        if (b >= 0) v[b] = 1'b0;
        return v;
    endfunction

    function automatic exp_t mk(input int c);
        exp_t e;
        e.code = 4'(c);
        e.gnt  = dec16_model(1'b0, 4'(c));
        return e;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_grant(input int budget, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int c = 0; c < budget; c++) begin
            tick();
            n++;
            if (en_ === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    always @(negedge clk_sys) begin
        if (mon_en) begin
            n_checks++;
            if ($countones(~gnt_) <= 1 && gnt_ === dec16_model(en_, code) &&
                (busy === 1'b1 || en_ === 1'b1))
                n_pass++;
            else
                $display("FAIL invariant t=%0t: en_=%b code=%0d gnt_=%h busy=%b", $time, en_, code, gnt_, busy);
        end
    end

    task automatic test_reset();
        exp_t e;
        clr  = 1'b1;
        rq_  = 16'h0000;
        done = 1'b0;
        tick();
        tick();
        mon_en = 1'b1;
        n_checks++;
        if (en_ === 1'b1 && gnt_ === 16'hFFFF && busy === 1'b0 && code === 4'd0 && tmo === 1'b0) n_pass++;
        else $display("FAIL reset_vals: en_=%b gnt_=%h busy=%b code=%0d tmo=%b, want 1 ffff 0 0 0", en_, gnt_, busy, code, tmo);
        clr = 1'b0;
        e.code = 4'd0;
        e.gnt  = 16'h7FFF;
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        n_checks++;
        if (en_ === 1'b0 && busy === 1'b1 && code === e.code && gnt_ === e.gnt) n_pass++;
        else $display("FAIL first_grant: en_=%b code=%0d gnt_=%h, want 0 %0d %h", en_, code, gnt_, e.code, e.gnt);
    endtask

    task automatic test_rotation();
        exp_t e;
        for (int k = 1; k <= 16; k++) sb.push_back(mk(k % 16));
        for (int k = 0; k < 16; k++) begin
            done = 1'b1;
            tick();
            done = 1'b0;
            n_checks++;
            if (en_ === 1'b1 && busy === 1'b1 && tmo === 1'b0 && gnt_ === 16'hFFFF) n_pass++;
            else $display("FAIL rot_release k=%0d: en_=%b busy=%b tmo=%b gnt_=%h, want 1 1 0 ffff", k, en_, busy, tmo, gnt_);
            tick();
            n_checks++;
            if (en_ === 1'b1 && busy === 1'b0) n_pass++;
            else $display("FAIL rot_idle k=%0d: en_=%b busy=%b, want 1 0", k, en_, busy);
            tick();
            e = sb.pop_front();
            n_checks++;
            if (en_ === 1'b0 && code === e.code && gnt_ === e.gnt) n_pass++;
            else $display("FAIL rot_grant k=%0d: en_=%b code=%0d gnt_=%h, want 0 %0d %h", k, en_, code, gnt_, e.code, e.gnt);
        end
    endtask

    task automatic test_pointer_skip();
        exp_t e;
        bit   ok;
        int   n;
        rq_  = req_low(3, -1);
        done = 1'b1;
        sb.push_back(mk(3));
        tick();
        done = 1'b0;
        wait_grant(6, ok, n);
        e = sb.pop_front();
        n_checks++;
        if (ok && code === e.code && gnt_ === e.gnt) n_pass++;
        else $display("FAIL skip_setup: ok=%b code=%0d gnt_=%h, want code=%0d %h", ok, code, gnt_, e.code, e.gnt);
        rq_    = req_low(2, 9);
        e.code = 4'd9;
        e.gnt  = 16'hFFBF;
        sb.push_back(e);
        wait_grant(6, ok, n);
        e = sb.pop_front();
        n_checks++;
        if (ok && n == 3 && code === e.code && gnt_ === e.gnt) n_pass++;
        else $display("FAIL skip_to_9: ok=%b cycles=%0d code=%0d gnt_=%h, want 3 cycles code=%0d %h", ok, n, code, gnt_, e.code, e.gnt);
        e.code = 4'd2;
        e.gnt  = 16'hDFFF;
        sb.push_back(e);
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_grant(6, ok, n);
        e = sb.pop_front();
        n_checks++;
        if (ok && n == 2 && code === e.code && gnt_ === e.gnt) n_pass++;
        else $display("FAIL skip_wrap_2: ok=%b cycles=%0d code=%0d gnt_=%h, want 2 cycles code=%0d %h", ok, n, code, gnt_, e.code, e.gnt);
    endtask

    task automatic test_withdrawal();
        exp_t e;
        bit   ok;
        int   n;
        rq_ = req_low(5, -1);
        sb.push_back(mk(5));
        wait_grant(6, ok, n);
        e = sb.pop_front();
        n_checks++;
        if (ok && code === e.code && gnt_ === e.gnt) n_pass++;
        else $display("FAIL wd_grant: ok=%b code=%0d gnt_=%h, want code=%0d %h", ok, code, gnt_, e.code, e.gnt);
        rq_ = '1;
        tick();
        n_checks++;
        if (en_ === 1'b1 && gnt_ === 16'hFFFF && tmo === 1'b0 && busy === 1'b1) n_pass++;
        else $display("FAIL wd_release: en_=%b gnt_=%h tmo=%b busy=%b, want 1 ffff 0 1", en_, gnt_, tmo, busy);
        tick();
        n_checks++;
        if (en_ === 1'b1 && busy === 1'b0 && tmo === 1'b0) n_pass++;
        else $display("FAIL wd_idle: en_=%b busy=%b tmo=%b, want 1 0 0", en_, busy, tmo);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        n_checks++;
        if (en_ === 1'b1 && busy === 1'b0 && gnt_ === 16'hFFFF) n_pass++;
        else $display("FAIL done_in_idle: en_=%b busy=%b gnt_=%h, want 1 0 ffff", en_, busy, gnt_);
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   ok;
        int   n;
        int   low_cnt;
        rq_ = req_low(7, -1);
        sb.push_back(mk(7));
        wait_grant(4, ok, n);
        e = sb.pop_front();
        n_checks++;
        if (ok && n == 1 && code === e.code && gnt_ === e.gnt) n_pass++;
        else $display("FAIL tmo_grant: ok=%b cycles=%0d code=%0d gnt_=%h, want 1 cycle code=%0d", ok, n, code, gnt_, e.code);
        low_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (en_ !== 1'b0) break;
            low_cnt++;
            tick();
        end
        n_checks++;
        if (low_cnt == 4 && tmo === 1'b1 && busy === 1'b1 && en_ === 1'b1) n_pass++;
        else $display("FAIL tmo_expire: en_ low %0d cycles tmo=%b busy=%b, want 4 cycles tmo=1 busy=1", low_cnt, tmo, busy);
        tick();
        n_checks++;
        if (tmo === 1'b0 && busy === 1'b0 && en_ === 1'b1) n_pass++;
        else $display("FAIL tmo_pulse_end: tmo=%b busy=%b en_=%b, want 0 0 1", tmo, busy, en_);
        sb.push_back(mk(7));
        tick();
        e = sb.pop_front();
        n_checks++;
        if (en_ === 1'b0 && code === e.code && gnt_ === e.gnt) n_pass++;
        else $display("FAIL tmo_regrant: en_=%b code=%0d gnt_=%h, want 0 %0d %h", en_, code, gnt_, e.code, e.gnt);
        rq_ = req_low(7, 3);
        tick();
        tick();
        tick();
        n_checks++;
        if (en_ === 1'b0 && code === 4'd7) n_pass++;
        else $display("FAIL tmo_hold: en_=%b code=%0d, want 0 7", en_, code);
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++;
        if (en_ === 1'b1 && tmo === 1'b0 && busy === 1'b1) n_pass++;
        else $display("FAIL tmo_done_wins: en_=%b tmo=%b busy=%b, want 1 0 1", en_, tmo, busy);
        sb.push_back(mk(3));
        wait_grant(6, ok, n);
        e = sb.pop_front();
        n_checks++;
        if (ok && n == 2 && code === e.code && gnt_ === e.gnt) n_pass++;
        else $display("FAIL tmo_other_pending: ok=%b cycles=%0d code=%0d, want 2 cycles code=%0d", ok, n, code, e.code);
    endtask

    task automatic test_mid_reset();
        exp_t e;
        bit   ok;
        int   n;
        rq_ = req_low(12, -1);
        sb.push_back(mk(12));
        wait_grant(6, ok, n);
        e = sb.pop_front();
        n_checks++;
        if (ok && code === e.code && gnt_ === e.gnt) n_pass++;
        else $display("FAIL mr_grant: ok=%b code=%0d gnt_=%h, want code=%0d %h", ok, code, gnt_, e.code, e.gnt);
        tick();
        clr = 1'b1;
        rq_ = req_low(12, 0);
        tick();
        n_checks++;
        if (en_ === 1'b1 && gnt_ === 16'hFFFF && busy === 1'b0 && code === 4'd0 && tmo === 1'b0) n_pass++;
        else $display("FAIL mr_reset_vals: en_=%b gnt_=%h busy=%b code=%0d tmo=%b, want 1 ffff 0 0 0", en_, gnt_, busy, code, tmo);
        clr    = 1'b0;
        e.code = 4'd0;
        e.gnt  = 16'h7FFF;
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        n_checks++;
        if (en_ === 1'b0 && code === e.code && gnt_ === e.gnt) n_pass++;
        else $display("FAIL mr_first_grant: en_=%b code=%0d gnt_=%h, want 0 %0d %h", en_, code, gnt_, e.code, e.gnt);
    endtask

    initial begin
        clr  = 1'b1;
        rq_  = '1;
        done = 1'b0;
        test_reset();
        test_rotation();
        test_pointer_skip();
        test_withdrawal();
        test_timeout();
        test_mid_reset();
        rq_ = '1;
        tick();
        tick();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
